// File: rtl/lp805x_rand.sv
`default_nettype none
// ============================================================================
//  Module   : lp805x_rand
//  Purpose  : 32-bit PRNG peripheral; registered XOR of a Galois LFSR and a
//             xorshift32 generator, free-running with software reseed.
//  Revision : 1.0  initial release
// ============================================================================
module lp805x_rand #(
    parameter logic [31:0] LFSR_POLY = 32'h8020_0003,
    parameter logic [31:0] LFSR_INIT = 32'h0000_0001,
    parameter logic [31:0] XS_INIT   = 32'h0000_0001
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        loadseed_i,
    input  logic [31:0] seed_i,
    output logic [31:0] number_o
);

    logic [31:0] lfsr_q,   lfsr_d;
    logic [31:0] xs_q,     xs_d;
    logic [31:0] number_q, number_d;
    logic [31:0] xs_t1,    xs_t2;

    always_comb begin
        lfsr_d   = lfsr_q;
        xs_d     = xs_q;
        number_d = number_q;
        xs_t1    = xs_q ^ (xs_q << 13);
        xs_t2    = xs_t1 ^ (xs_t1 >> 17);
        if (loadseed_i) begin
            // A zero seed would lock both generators at zero forever.
            if (seed_i != 32'h0) begin
                lfsr_d = seed_i;
                xs_d   = seed_i;
            end else begin
                lfsr_d = LFSR_INIT;
                xs_d   = XS_INIT;
            end
        end else begin
            lfsr_d   = lfsr_q[0] ? ((lfsr_q >> 1) ^ LFSR_POLY) : (lfsr_q >> 1);
            xs_d     = xs_t2 ^ (xs_t2 << 5);
            number_d = lfsr_q ^ xs_q;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            lfsr_q   <= LFSR_INIT;
            xs_q     <= XS_INIT;
            number_q <= 32'h0;
        end else begin
            lfsr_q   <= lfsr_d;
            xs_q     <= xs_d;
            number_q <= number_d;
        end
    end

    assign number_o = number_q;

endmodule
`default_nettype wire

// File: tb/tb_lp805x_rand.sv
`default_nettype none
// ============================================================================
//  Module   : tb_lp805x_rand
//  Purpose  : Self-checking bench for lp805x_rand (directed vectors plus a
//             reference model for the randomly reseeded run).
//  Revision : 1.0  initial release
// ============================================================================
module tb_lp805x_rand;

    logic        clk;
    logic        reset;
    logic        loadseed_i;
    logic [31:0] seed_i;
    logic [31:0] number_o;

    int n_tests;
    int n_fail;

    logic [31:0] m_lfsr, m_xs, m_num;

    lp805x_rand dut (
        .clk        (clk),
        .reset      (reset),
        .loadseed_i (loadseed_i),
        .seed_i     (seed_i),
        .number_o   (number_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] f_lfsr(input logic [31:0] s);
        logic [31:0] r;
        r = {1'b0, s[31:1]};
        if (s[0]) r = r ^ 32'h8020_0003;
        return r;
    endfunction

    function automatic logic [31:0] f_xs(input logic [31:0] x);
        logic [31:0] a;
        a = x ^ {x[18:0], 13'h0};
        a = a ^ {17'h0, a[31:17]};
        return a ^ {a[26:0], 5'h0};
    endfunction

    // One clock with the given inputs; the model advances on the same edge.
    task automatic cyc(input logic rst, input logic ld, input logic [31:0] sd);
        reset      = rst;
        loadseed_i = ld;
        seed_i     = sd;
        @(posedge clk);
        if (rst) begin
            m_lfsr = 32'h1;
            m_xs   = 32'h1;
            m_num  = 32'h0;
        end else if (ld) begin
            m_lfsr = (sd != 0) ? sd : 32'h1;
            m_xs   = (sd != 0) ? sd : 32'h1;
        end else begin
            m_num  = m_lfsr ^ m_xs;
            m_lfsr = f_lfsr(m_lfsr);
            m_xs   = f_xs(m_xs);
        end
        #1;
    endtask

    task automatic chk_start_seq(input string tag);
        cyc(1'b0, 1'b0, 32'h0); chk({tag, "_e1"}, number_o, 32'h0000_0000);
        cyc(1'b0, 1'b0, 32'h0); chk({tag, "_e2"}, number_o, 32'h8024_2022);
        cyc(1'b0, 1'b0, 32'h0); chk({tag, "_e3"}, number_o, 32'hC438_0603);
    endtask

    initial begin
        logic [31:0] held;
        logic [31:0] sd;
        n_tests    = 0;
        n_fail     = 0;
        reset      = 1'b1;
        loadseed_i = 1'b0;
        seed_i     = 32'h0;
        m_lfsr     = 32'h1;
        m_xs       = 32'h1;
        m_num      = 32'h0;

        // Reset and post-reset sequence
        cyc(1'b1, 1'b0, 32'h0);
        cyc(1'b1, 1'b0, 32'h0);
        chk("reset_num", number_o, 32'h0);
        chk("reset_lfsr", dut.lfsr_q, 32'h1);
        chk("reset_xs", dut.xs_q, 32'h1);
        chk_start_seq("post_reset");

        // Free run, then reseed with 1: output holds, then sequence repeats
        for (int i = 3; i < 20; i++) cyc(1'b0, 1'b0, 32'h0);
        chk("run20_model", number_o, m_num);
        held = m_num;
        cyc(1'b0, 1'b1, 32'h1);
        chk("seed1_hold", number_o, held);
        chk_start_seq("seed1");

        // Zero seed behaves like reset state
        for (int i = 0; i < 7; i++) cyc(1'b0, 1'b0, 32'h0);
        held = m_num;
        cyc(1'b0, 1'b1, 32'h0);
        chk("seed0_hold", number_o, held);
        chk_start_seq("seed0");

        // Held load keeps output constant and never steps
        held = m_num;
        for (int i = 0; i < 5; i++) begin
            cyc(1'b0, 1'b1, 32'hDEAD_BEEF);
            chk("hold_load", number_o, held);
        end
        chk("hold_lfsr", dut.lfsr_q, 32'hDEAD_BEEF);
        cyc(1'b0, 1'b0, 32'h0);
        chk("release_e1", number_o, 32'h0);
        for (int i = 0; i < 4; i++) begin
            cyc(1'b0, 1'b0, 32'h0);
            chk("release_step", number_o, m_num);
        end

        // Reset beats a simultaneous load
        for (int i = 0; i < 6; i++) cyc(1'b0, 1'b0, 32'h0);
        cyc(1'b1, 1'b1, 32'h1234_5678);
        chk("rst_pri_num", number_o, 32'h0);
        chk("rst_pri_lfsr", dut.lfsr_q, 32'h1);
        chk("rst_pri_xs", dut.xs_q, 32'h1);
        chk_start_seq("rst_pri");

        // Randomly reseeded run against the reference model
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 63) == 0) begin
                sd = ($urandom_range(0, 3) == 0) ? 32'h0 : $urandom;
                cyc(1'b0, 1'b1, sd);
            end else begin
                cyc(1'b0, 1'b0, 32'h0);
            end
            chk("rand_num", number_o, m_num);
            if (dut.lfsr_q == 32'h0 || dut.xs_q == 32'h0) begin
                chk("rand_nonzero", 32'h0, 32'h1);
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
